// File: rtl/tdm_demux8_pkg.sv
// Shared definitions for the TDM 8-channel link, used by the receive-side
// demultiplexer and the transmit-side serializer.
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CH_A = 3'd0;
  localparam logic [CNT_W-1:0] CH_B = 3'd1;
  localparam logic [CNT_W-1:0] CH_C = 3'd2;
  localparam logic [CNT_W-1:0] CH_D = 3'd3;
  localparam logic [CNT_W-1:0] CH_E = 3'd4;
  localparam logic [CNT_W-1:0] CH_F = 3'd5;
  localparam logic [CNT_W-1:0] CH_G = 3'd6;
  localparam logic [CNT_W-1:0] CH_H = 3'd7;

endpackage

// File: rtl/tdm_demux8_ch_counter.sv
// Channel index counter: load-to-B on sync, increment on enable, flag the
// enabled step out of channel H so the parent can complete the frame.
module tdm_ch_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A sync sample is always channel A, so the next expected index is B.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CH_B;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CH_A;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & (cnt_q == CH_H);

endmodule

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: aligns on sync, collects eight channel samples
// into shadow registers and publishes complete frames on held outputs A..H.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          sync,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] C,
  output logic [DW-1:0] D,
  output logic [DW-1:0] E,
  output logic [DW-1:0] F,
  output logic [DW-1:0] G,
  output logic [DW-1:0] H,
  output logic          S2,
  output logic          S1,
  output logic          S0,
  output logic          frame_valid,
  output logic          sync_err
);

  state_t                         state_q;
  logic [NUM_CH-2:0][DW-1:0]      shadow_q;
  logic [NUM_CH-1:0][DW-1:0]      out_q;
  logic                           frame_valid_q;
  logic                           sync_err_q;

  logic [CNT_W-1:0]               cnt;
  logic                           cnt_load;
  logic                           cnt_en;
  logic                           cnt_wrap;

  // In HUNT only a sync moves the counter; unsynced samples leave it at A.
  assign cnt_load = din_valid & sync;
  assign cnt_en   = din_valid & ~sync & (state_q == RUN);

  tdm_ch_counter u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (cnt_en),
    .load_i (cnt_load),
    .cnt_o  (cnt),
    .wrap_o (cnt_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          HUNT: begin
            if (sync) begin
              shadow_q[CH_A] <= din;
              state_q        <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // Stale B..G shadows are harmless: all are rewritten before H.
              shadow_q[CH_A] <= din;
              sync_err_q     <= (cnt != CH_A);
            end else if (cnt_wrap) begin
              out_q         <= {din, shadow_q};
              frame_valid_q <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_CH - 1; i++) begin
                if (cnt == CNT_W'(i)) begin
                  shadow_q[i] <= din;
                end
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign A = out_q[CH_A];
  assign B = out_q[CH_B];
  assign C = out_q[CH_C];
  assign D = out_q[CH_D];
  assign E = out_q[CH_E];
  assign F = out_q[CH_F];
  assign G = out_q[CH_G];
  assign H = out_q[CH_H];

  assign S2 = cnt[2];
  assign S1 = cnt[1];
  assign S0 = cnt[0];

  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule
